// File: rtl/bist_response_analyzer.sv
// rtl/bist_response_analyzer.sv - BIST read-side response analyzer with fail statistics and fail-log FIFO
//
// Purpose: compares memory read beats against the generator's expected
// pattern, keeps pass/fail statistics and logs failing {addr, syndrome}
// pairs in a small first-word fall-through FIFO.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   start, stop                   one-cycle run control pulses
//   rd_vld/rd_addr/rd_data/exp_data  read beat under test
//   busy, done                    run status (RUN|DRAIN, DONE)
//   fail, fail_cnt                sticky fail flag, saturating mismatch count
//   first_addr, first_syn         first mismatch of the run
//   log_vld/log_addr/log_syn/log_pop  fail-log FIFO head and pop
//   log_ovf                       sticky: a log entry was dropped
//   fail_bits                     OR of all syndromes (BIST_RA_BITMAP_EN only)
//
// Optional feature macro: BIST_RA_BITMAP_EN

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module bist_response_analyzer #(
  parameter int AW   = `ADDR_WIDTH,
  parameter int DW   = `DATA_WIDTH,
  parameter int CW   = 16,
  parameter int LOGD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          rd_vld,
  input  logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  input  logic [DW-1:0] exp_data,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [CW-1:0] fail_cnt,
  output logic [AW-1:0] first_addr,
  output logic [DW-1:0] first_syn,
  output logic          log_vld,
  output logic [AW-1:0] log_addr,
  output logic [DW-1:0] log_syn,
  input  logic          log_pop,
  output logic          log_ovf
`ifdef BIST_RA_BITMAP_EN
  ,
  output logic [DW-1:0] fail_bits
`endif
);

  // FIFO holds LOGD entries; pointers carry one extra wrap bit so that
  // full and empty are distinguishable without a separate counter.
  localparam int IW = $clog2(LOGD);
  localparam int PW = IW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;

  logic          r_s1_vld;
  logic [AW-1:0] r_s1_addr;
  logic [DW-1:0] r_s1_syn;

  logic [AW-1:0] r_mem_addr [LOGD];
  logic [DW-1:0] r_mem_syn  [LOGD];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;

  logic          w_accept;
  logic          w_hit;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    if (start) begin
      w_next = S_RUN;
    end else begin
      case (r_state)
        S_RUN:   if (stop) w_next = S_DRAIN;
        // Stage 1 never loads outside RUN, so one cycle of DRAIN empties it.
        S_DRAIN: w_next = S_DONE;
        default: w_next = r_state;
      endcase
    end
    case (r_state)
      S_RUN, S_DRAIN: busy = 1'b1;
      S_DONE:         done = 1'b1;
      default:        ;
    endcase
  end

  // A beat riding on the start pulse belongs to the new run.
  assign w_accept = rd_vld && (r_state == S_RUN || start);

  // Stage-2 results are discarded on a start edge: statistics restart clean
  // and a beat still in flight from the previous run is dropped.
  assign w_hit   = r_s1_vld && (r_s1_syn != '0) && !start;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[IW-1:0] == r_rp[IW-1:0]) && (r_wp[IW] != r_rp[IW]);
  assign w_pop   = log_pop && !w_empty && !start;
  // A pop frees the slot on the same edge, so a push into a full FIFO is
  // still taken when it coincides with a pop.
  assign w_push  = w_hit && (!w_full || w_pop);

  assign log_vld  = !w_empty;
  assign log_addr = w_empty ? '0 : r_mem_addr[r_rp[IW-1:0]];
  assign log_syn  = w_empty ? '0 : r_mem_syn[r_rp[IW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_s1_vld   <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_syn   <= '0;
      fail       <= 1'b0;
      fail_cnt   <= '0;
      first_addr <= '0;
      first_syn  <= '0;
      log_ovf    <= 1'b0;
      r_wp       <= '0;
      r_rp       <= '0;
    end else begin
      r_state   <= w_next;
      r_s1_vld  <= w_accept;
      r_s1_addr <= rd_addr;
      r_s1_syn  <= rd_data ^ exp_data;
      if (start) begin
        fail       <= 1'b0;
        fail_cnt   <= '0;
        first_addr <= '0;
        first_syn  <= '0;
        log_ovf    <= 1'b0;
        r_wp       <= '0;
        r_rp       <= '0;
      end else begin
        if (w_hit) begin
          fail <= 1'b1;
          if (fail_cnt != {CW{1'b1}}) fail_cnt <= fail_cnt + 1'b1;
          if (!fail) begin
            first_addr <= r_s1_addr;
            first_syn  <= r_s1_syn;
          end
          if (!w_push) log_ovf <= 1'b1;
        end
        if (w_push) r_wp <= r_wp + 1'b1;
        if (w_pop)  r_rp <= r_rp + 1'b1;
      end
    end
  end

  // Log storage needs no reset: entries are only visible behind log_vld.
  always_ff @(posedge clk) begin
    if (w_push && !start) begin
      r_mem_addr[r_wp[IW-1:0]] <= r_s1_addr;
      r_mem_syn[r_wp[IW-1:0]]  <= r_s1_syn;
    end
  end

`ifdef BIST_RA_BITMAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_bits <= '0;
    end else if (start) begin
      fail_bits <= '0;
    end else if (w_hit) begin
      fail_bits <= fail_bits | r_s1_syn;
    end
  end
`endif

endmodule

// File: tb/tb_bist_response_analyzer.sv
// tb/tb_bist_response_analyzer.sv - self-checking bench for bist_response_analyzer
module tb_bist_response_analyzer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, rd_vld, log_pop;
  logic [7:0]  rd_addr, rd_data, exp_data;

  logic        busy, done, fail, log_vld, log_ovf;
  logic [15:0] fail_cnt;
  logic [7:0]  first_addr, first_syn, log_addr, log_syn;
`ifdef BIST_RA_BITMAP_EN
  logic [7:0]  fail_bits, d2_fail_bits;
`endif

  logic        d2_busy, d2_done, d2_fail, d2_log_vld, d2_log_ovf;
  logic [1:0]  d2_fail_cnt;
  logic [7:0]  d2_first_addr, d2_first_syn, d2_log_addr, d2_log_syn;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  bist_response_analyzer #(.AW(8), .DW(8), .CW(16), .LOGD(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .rd_vld(rd_vld), .rd_addr(rd_addr), .rd_data(rd_data), .exp_data(exp_data),
    .busy(busy), .done(done), .fail(fail), .fail_cnt(fail_cnt),
    .first_addr(first_addr), .first_syn(first_syn),
    .log_vld(log_vld), .log_addr(log_addr), .log_syn(log_syn),
    .log_pop(log_pop), .log_ovf(log_ovf)
`ifdef BIST_RA_BITMAP_EN
    , .fail_bits(fail_bits)
`endif
  );

  bist_response_analyzer #(.AW(8), .DW(8), .CW(2), .LOGD(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .rd_vld(rd_vld), .rd_addr(rd_addr), .rd_data(rd_data), .exp_data(exp_data),
    .busy(d2_busy), .done(d2_done), .fail(d2_fail), .fail_cnt(d2_fail_cnt),
    .first_addr(d2_first_addr), .first_syn(d2_first_syn),
    .log_vld(d2_log_vld), .log_addr(d2_log_addr), .log_syn(d2_log_syn),
    .log_pop(log_pop), .log_ovf(d2_log_ovf)
`ifdef BIST_RA_BITMAP_EN
    , .fail_bits(d2_fail_bits)
`endif
  );

  // Behavioural model: 0 idle, 1 run, 2 drain, 3 done
  int          m_state;
  bit          m_pv;
  logic [7:0]  m_pa, m_ps;
  bit          m_fail;
  int          m_cnt;
  logic [7:0]  m_fa, m_fs;
  logic [15:0] m_log[$];
  bit          m_ovf;
  logic [7:0]  m_bits;

  task automatic model_reset();
    m_state = 0; m_pv = 0; m_pa = 0; m_ps = 0; m_fail = 0; m_cnt = 0;
    m_fa = 0; m_fs = 0; m_log.delete(); m_ovf = 0; m_bits = 0;
  endtask

  task automatic model_step();
    bit         acc;
    bit         pop_ok;
    logic [7:0] syn;
    if (!rst_n) begin
      model_reset();
      return;
    end
    acc = rd_vld && (start || m_state == 1);
    syn = rd_data ^ exp_data;
    if (start) begin
      m_fail = 0; m_cnt = 0; m_fa = 0; m_fs = 0; m_ovf = 0; m_bits = 0;
      m_log.delete();
      m_state = 1;
    end else begin
      pop_ok = log_pop && (m_log.size() > 0);
      if (pop_ok) void'(m_log.pop_front());
      if (m_pv && m_ps != 0) begin
        if (!m_fail) begin m_fa = m_pa; m_fs = m_ps; end
        m_fail = 1;
        m_cnt++;
        m_bits = m_bits | m_ps;
        if (m_log.size() < 4) m_log.push_back({m_pa, m_ps});
        else m_ovf = 1;
      end
      if (m_state == 1 && stop) m_state = 2;
      else if (m_state == 2) m_state = 3;
    end
    m_pv = acc; m_pa = rd_addr; m_ps = syn;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", busy, (m_state == 1 || m_state == 2));
      chk("done", done, (m_state == 3));
      chk("fail", fail, m_fail);
      chk("fail_cnt", fail_cnt, (m_cnt > 65535) ? 65535 : m_cnt);
      chk("first_addr", first_addr, m_fa);
      chk("first_syn", first_syn, m_fs);
      chk("log_vld", log_vld, (m_log.size() > 0));
      chk("log_addr", log_addr, (m_log.size() > 0) ? m_log[0][15:8] : 8'h00);
      chk("log_syn", log_syn, (m_log.size() > 0) ? m_log[0][7:0] : 8'h00);
      chk("log_ovf", log_ovf, m_ovf);
      chk("d2_fail", d2_fail, m_fail);
      chk("d2_fail_cnt", d2_fail_cnt, (m_cnt > 3) ? 3 : m_cnt);
`ifdef BIST_RA_BITMAP_EN
      chk("fail_bits", fail_bits, m_bits);
`endif
    end
  end

  task automatic cyc(input bit st, input bit sp, input bit v, input logic [7:0] a,
                     input logic [7:0] rd, input logic [7:0] ex, input bit pop);
    start = st; stop = sp; rd_vld = v; rd_addr = a; rd_data = rd; exp_data = ex; log_pop = pop;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 0; stop = 0; rd_vld = 0; log_pop = 0;
    rd_addr = 0; rd_data = 0; exp_data = 0;
    model_reset();
    chk_on = 1'b1;
    idle(2);
    chk("rst_busy", busy, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    rst_n = 1'b1;
    idle(1);

    // 1: clean run
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, i[7:0], 8'h3C ^ i[7:0], 8'h3C ^ i[7:0], 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("t1_done_early", done, 0);
    idle(1);
    chk("t1_done", done, 1);
    chk("t1_fail", fail, 0);
    chk("t1_cnt", fail_cnt, 0);
    chk("t1_log_vld", log_vld, 0);

    // 2: two mismatches, first-fail capture, FIFO order
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 8'h03, 8'hA5, 8'hA4, 0);
    chk("t2_fail_1edge", fail, 0);
    cyc(0, 0, 1, 8'h07, 8'h00, 8'hFF, 0);
    chk("t2_fail_2edge", fail, 1);
    idle(1);
    chk("t2_cnt", fail_cnt, 2);
    chk("t2_first_addr", first_addr, 8'h03);
    chk("t2_first_syn", first_syn, 8'h01);
    chk("t2_head_addr", log_addr, 8'h03);
    chk("t2_head_syn", log_syn, 8'h01);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("t2_next_addr", log_addr, 8'h07);
    chk("t2_next_syn", log_syn, 8'hFF);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("t2_empty", log_vld, 0);

    // 3: overflow, then push coinciding with pop while full
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 8'h10 + i[7:0], i[7:0] + 8'h01, 8'h00, 0);
    idle(2);
    chk("t3_cnt", fail_cnt, 6);
    chk("t3_ovf", log_ovf, 1);
    chk("t3_head", log_addr, 8'h10);
    cyc(0, 0, 1, 8'h20, 8'h0F, 8'h00, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("t3_tail_addr", log_addr, 8'h20);
    chk("t3_cnt7", fail_cnt, 7);

    // 4: stop with a mismatching beat; start+stop; start during DRAIN
    cyc(0, 1, 1, 8'h30, 8'h55, 8'h54, 0);
    chk("t4_done_early", done, 0);
    idle(1);
    chk("t4_done", done, 1);
    chk("t4_cnt", fail_cnt, 8);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("t4_ss_busy", busy, 1);
    chk("t4_ss_cnt", fail_cnt, 0);
    idle(1);
    chk("t4_ss_run", busy, 1);
    cyc(0, 1, 1, 8'h31, 8'h01, 8'h00, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(2);
    chk("t4_abort_cnt", fail_cnt, 0);
    chk("t4_abort_busy", busy, 1);

    // 5: asynchronous reset mid-run
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'h40 + i[7:0], 8'hF0, 8'h0F, 0);
    idle(1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("t5_cnt", fail_cnt, 5);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_busy0", busy, 0);
    chk("t5_fail0", fail, 0);
    chk("t5_cnt0", fail_cnt, 0);
    chk("t5_log0", log_vld, 0);
    chk("t5_ovf0", log_ovf, 0);
    chk("t5_first0", first_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'h50, 8'h11, 8'h22, 0);
    idle(2);
    chk("t5_ignored", fail_cnt, 0);

    // 6: CW=2 saturation and column bitmap
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'h60 + i[7:0], (i % 2 == 0) ? 8'h01 : 8'h80, 8'h00, 0);
    idle(2);
    chk("t6_d2_sat", d2_fail_cnt, 3);
    chk("t6_cnt", fail_cnt, 5);
`ifdef BIST_RA_BITMAP_EN
    chk("t6_bits", fail_bits, 8'h81);
`endif
    cyc(0, 1, 0, 0, 0, 0, 0);
    idle(2);
    chk("t6_done", done, 1);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
